// File: rtl/wb_fib_regbank.sv
`default_nettype none
// ============================================================================
// Module   : wb_fib_regbank
// Brief    : Wishbone classic register bank for NUM_CH Fibonacci channels
//            (CTRL, masked W1C IRQ, scratch FIFO, panic, channel read-back).
//            Optional feature macro: WB_FIB_SNAPSHOT_EN (CTRL[1] channel snapshot).
// Revision : 1.0
// ============================================================================
module wb_fib_regbank #(
    parameter logic [31:0] BASE_ADDRESS = 32'h30000000,
    parameter int          CLOCK_WIDTH  = 6,
    parameter int          NUM_CH       = 2,
    parameter int          CH_WIDTH     = 30,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                         wb_clk_i,
    input  logic                         reset,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_we_i,
    input  logic [3:0]                   wbs_sel_i,
    input  logic [31:0]                  wbs_adr_i,
    input  logic [31:0]                  wbs_dat_i,
    output logic                         wbs_ack_o,
    output logic [31:0]                  wbs_dat_o,
    input  logic [NUM_CH*CH_WIDTH-1:0]   ch_val_i,
    output logic                         switch,
    output logic [CLOCK_WIDTH-1:0]       clock_sel,
    output logic [2:0]                   irq
);
    localparam int            c_AW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0]   c_ID        = 32'h4669626f;
    localparam logic [31:0]   c_PANIC_RST = 32'hf00df00d;
    localparam logic [c_AW:0] c_FULL      = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_AW:0] c_ONE       = (c_AW+1)'(1);
    localparam logic [5:0]    c_IDX_ID    = 6'h00;
    localparam logic [5:0]    c_IDX_CTRL  = 6'h01;
    localparam logic [5:0]    c_IDX_MASK  = 6'h02;
    localparam logic [5:0]    c_IDX_STAT  = 6'h03;
    localparam logic [5:0]    c_IDX_FIFO  = 6'h04;
    localparam logic [5:0]    c_IDX_LVL   = 6'h05;
    localparam logic [5:0]    c_IDX_PANIC = 6'h06;

    logic [31:0]      w_off;
    logic [5:0]       w_idx;
    logic             w_req, w_wr, w_rd;
    logic [31:0]      w_bmask;
    logic [31:0]      w_ctrl_cur, w_ctrl_new, w_mask_new, w_panic_new;
    logic [31:0]      w_rdata;
    logic             w_wr_ctrl, w_wr_mask, w_push, w_pop, w_ovf_set, w_panic_set;
    logic [1:0]       w_w1c;
    logic [2:0]       w_stat;
    logic [c_AW:0]    w_count;
    logic             w_full, w_empty;
    logic             w_unused;
    logic [7:0][31:0] w_ch_live, w_ch;

    logic [2:0]       r_mask;
    logic [1:0]       r_sticky;   // {panic, overflow}
    logic [31:0]      r_panic;
    logic [c_AW:0]    r_wr_ptr, r_rd_ptr;
    logic [31:0]      r_mem [FIFO_DEPTH];

    assign w_off   = wbs_adr_i - BASE_ADDRESS;
    assign w_idx   = w_off[7:2];
    assign w_req   = wbs_stb_i & wbs_cyc_i & (w_off[31:8] == 24'h0) & ~wbs_ack_o;
    assign w_wr    = w_req & wbs_we_i;
    assign w_rd    = w_req & ~wbs_we_i;
    assign w_bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    always_comb begin
        w_ctrl_cur                      = 32'h0;
        w_ctrl_cur[0]                   = switch;
        w_ctrl_cur[8 +: CLOCK_WIDTH]    = clock_sel;
    end

    assign w_ctrl_new  = (w_ctrl_cur & ~w_bmask)         | (wbs_dat_i & w_bmask);
    assign w_mask_new  = ({29'h0, r_mask} & ~w_bmask)    | (wbs_dat_i & w_bmask);
    assign w_panic_new = (r_panic & ~w_bmask)            | (wbs_dat_i & w_bmask);
    assign w_unused    = &{1'b0, w_off[1:0], w_ctrl_new, w_mask_new};

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == c_FULL);
    assign w_empty = (w_count == '0);
    assign w_stat  = {r_sticky, ~w_empty};

    assign w_wr_ctrl   = w_wr && (w_idx == c_IDX_CTRL);
    assign w_wr_mask   = w_wr && (w_idx == c_IDX_MASK);
    assign w_push      = w_wr && (w_idx == c_IDX_FIFO);
    assign w_pop       = w_rd && (w_idx == c_IDX_FIFO) && !w_empty;
    assign w_ovf_set   = w_push && w_full;
    assign w_panic_set = w_wr && (w_idx == c_IDX_PANIC);
    assign w_w1c       = (w_wr && (w_idx == c_IDX_STAT) && wbs_sel_i[0]) ? wbs_dat_i[2:1] : 2'b00;

    // Unimplemented channel slots read as zero so the read mux can index all eight.
    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
        if (gi < NUM_CH) begin : g_live
            assign w_ch_live[gi] = 32'(ch_val_i[gi*CH_WIDTH +: CH_WIDTH]);
        end else begin : g_pad
            assign w_ch_live[gi] = 32'h0;
        end
    end

`ifdef WB_FIB_SNAPSHOT_EN
    logic [7:0][31:0] r_shadow;

    always_ff @(posedge wb_clk_i) begin
        if (reset)
            r_shadow <= '0;
        else if (w_wr_ctrl && wbs_sel_i[0] && wbs_dat_i[1])
            r_shadow <= w_ch_live;
    end

    assign w_ch = r_shadow;
`else
    assign w_ch = w_ch_live;
`endif

    always_comb begin
        w_rdata = 32'h0;
        case (w_idx)
            c_IDX_ID:    w_rdata = c_ID;
            c_IDX_CTRL:  w_rdata = w_ctrl_cur;
            c_IDX_MASK:  w_rdata = {29'h0, r_mask};
            c_IDX_STAT:  w_rdata = {29'h0, w_stat};
            c_IDX_FIFO:  w_rdata = w_empty ? 32'h0 : r_mem[r_rd_ptr[c_AW-1:0]];
            c_IDX_LVL:   w_rdata = 32'(w_count);
            c_IDX_PANIC: w_rdata = r_panic;
            default: begin
                if (w_idx[5:3] == 3'b001)
                    w_rdata = w_ch[w_idx[2:0]];
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            switch    <= 1'b1;
            clock_sel <= CLOCK_WIDTH'(1);
            irq       <= 3'b000;
            r_mask    <= 3'b000;
            r_sticky  <= 2'b00;
            r_panic   <= c_PANIC_RST;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
        end else begin
            wbs_ack_o <= w_req;
            wbs_dat_o <= w_rd ? w_rdata : 32'h0;
            if (w_wr_ctrl) begin
                switch    <= w_ctrl_new[0];
                clock_sel <= w_ctrl_new[8 +: CLOCK_WIDTH];
            end
            if (w_wr_mask)
                r_mask <= w_mask_new[2:0];
            // Hardware set wins over a simultaneous W1C clear.
            r_sticky <= (r_sticky & ~w_w1c) | {w_panic_set, w_ovf_set};
            if (w_panic_set)
                r_panic <= w_panic_new;
            if (w_push && !w_full)
                r_wr_ptr <= r_wr_ptr + c_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_ONE;
            irq <= w_stat & r_mask;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!reset && w_push && !w_full)
            r_mem[r_wr_ptr[c_AW-1:0]] <= wbs_dat_i;
    end

endmodule
`default_nettype wire
